// File: rtl/stage_seq_pkg.sv
// Shared types, constants and helpers for the stage sequencer.
package stage_seq_pkg;

   localparam int unsigned DEFAULT_NUM_STAGES = 5;
   localparam int unsigned STAGE_FIRST        = 1;
   localparam int unsigned MAX_STAGES         = 1024;

   typedef enum logic [1:0] {
      ACT_ADVANCE,
      ACT_RETIRE,
      ACT_HOLD,
      ACT_RESTART
   } seq_action_e;

   function automatic bit stage_cfg_legal(input int unsigned num_stages,
                                          input int unsigned cw);
      return (num_stages >= 2) && (cw >= 1) && (cw < 32) &&
             (num_stages <= MAX_STAGES) &&
             (num_stages <= ((32'd1 << cw) - 32'd1));
   endfunction

   // Out-of-range counts decode to stage 1 so the vector stays one-hot.
   function automatic logic [MAX_STAGES-1:0] stage_onehot(input int unsigned count,
                                                          input int unsigned num_stages);
      logic [MAX_STAGES-1:0] oh;
      oh = {{(MAX_STAGES-1){1'b0}}, 1'b1};
      if (count >= STAGE_FIRST && count <= num_stages) begin
         oh = oh << (count - STAGE_FIRST);
      end
      return oh;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low reset.
module sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             inc_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle instruction stage sequencer with stall, early end and flush.
// Optional performance counters are built when STAGE_SEQ_PERF_EN is defined.
module stage_sequencer
   import stage_seq_pkg::*;
#(
   parameter int unsigned NUM_STAGES = DEFAULT_NUM_STAGES,
   parameter int unsigned CW         = 3,
   parameter int unsigned PERF_W     = 16
) (
   input  logic                  Clock,
   input  logic                  ResetN,
   input  logic                  Stall,
   input  logic                  EndEarly,
   input  logic                  Flush,
   output logic [CW-1:0]         ClockCount,
   output logic [NUM_STAGES-1:0] StageOneHot,
   output logic                  LastStage,
   output logic                  InstrDone,
   output logic [PERF_W-1:0]     RetiredCount,
   output logic [PERF_W-1:0]     StallCount
);

   localparam logic [CW-1:0] FIRST = CW'(STAGE_FIRST);
   localparam logic [CW-1:0] LAST  = CW'(NUM_STAGES);

   generate
      if (!stage_cfg_legal(NUM_STAGES, CW)) begin : g_bad_cfg
         $error("stage_sequencer: NUM_STAGES must be in 2..2^CW-1");
      end
   endgenerate

   logic [CW-1:0] count_q, count_d;
   logic          done_q, done_d;
   logic          count_legal;
   seq_action_e   action;

   assign count_legal = (count_q >= FIRST) && (count_q <= LAST);

   always_comb begin
      LastStage = (count_q == LAST) || EndEarly;
      if (Flush || !count_legal) begin
         action = ACT_RESTART;
      end else if (Stall) begin
         action = ACT_HOLD;
      end else if (LastStage) begin
         action = ACT_RETIRE;
      end else begin
         action = ACT_ADVANCE;
      end
   end

   always_comb begin
      count_d = count_q;
      done_d  = 1'b0;
      case (action)
         ACT_RESTART: count_d = FIRST;
         ACT_HOLD:    count_d = count_q;
         ACT_RETIRE: begin
            count_d = FIRST;
            done_d  = 1'b1;
         end
         ACT_ADVANCE: count_d = count_q + 1'b1;
         default:     count_d = FIRST;
      endcase
   end

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         count_q <= FIRST;
         done_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         done_q  <= done_d;
      end
   end

   assign ClockCount  = count_q;
   assign InstrDone   = done_q;
   assign StageOneHot = NUM_STAGES'(stage_onehot(32'(count_q), NUM_STAGES));

`ifdef STAGE_SEQ_PERF_EN
   logic retire_inc, stall_inc;

   assign retire_inc = (action == ACT_RETIRE);
   assign stall_inc  = Stall && !Flush;

   sat_counter #(.WIDTH(PERF_W)) u_retired (
      .clk_i   (Clock),
      .rst_ni  (ResetN),
      .inc_i   (retire_inc),
      .count_o (RetiredCount)
   );

   sat_counter #(.WIDTH(PERF_W)) u_stalled (
      .clk_i   (Clock),
      .rst_ni  (ResetN),
      .inc_i   (stall_inc),
      .count_o (StallCount)
   );
`else
   assign RetiredCount = '0;
   assign StallCount   = '0;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench: a 5-stage instance (4-bit perf counters) and a 7-stage instance share stimulus.
module tb_stage_sequencer;

   logic        clk;
   logic        rst_n, stall, ee, flush;
   logic [2:0]  cc5, cc7;
   logic [4:0]  oh5;
   logic [6:0]  oh7;
   logic        last5, last7, done5, done7;
   logic [3:0]  ret5, stl5;
   logic [15:0] ret7, stl7;

   stage_sequencer #(.NUM_STAGES(5), .CW(3), .PERF_W(4)) dut5 (
      .Clock(clk), .ResetN(rst_n), .Stall(stall), .EndEarly(ee), .Flush(flush),
      .ClockCount(cc5), .StageOneHot(oh5), .LastStage(last5), .InstrDone(done5),
      .RetiredCount(ret5), .StallCount(stl5)
   );

   stage_sequencer #(.NUM_STAGES(7), .CW(3), .PERF_W(16)) dut7 (
      .Clock(clk), .ResetN(rst_n), .Stall(stall), .EndEarly(ee), .Flush(flush),
      .ClockCount(cc7), .StageOneHot(oh7), .LastStage(last7), .InstrDone(done7),
      .RetiredCount(ret7), .StallCount(stl7)
   );

   typedef struct {
      string       name;
      int unsigned cnt5;
      logic        done5, last5;
      int unsigned ret5, stl5;
      int unsigned cnt7;
      logic        done7, last7;
      int unsigned ret7, stl7;
   } exp_t;

   exp_t        q[$];
   exp_t        x;
   int unsigned n_chk = 0;
   int unsigned n_pass = 0;
   int unsigned m_ret5 = 0, m_ret7 = 0, m_stl = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int unsigned sat(input int unsigned v, input int unsigned lim);
`ifdef STAGE_SEQ_PERF_EN
      return (v > lim) ? lim : v;
`else
      return 0;
`endif
   endfunction

   task automatic chk(input string name, input string what,
                      input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s.%s: got %0d expected %0d", name, what, act, req);
   endtask

   // Drive one cycle's inputs just after the edge and queue what that cycle must show.
   task automatic step(input string name, input logic s, input logic e, input logic f,
                       input logic r, input int unsigned c5, input logic d5,
                       input int unsigned c7, input logic d7);
      exp_t y;
      @(posedge clk); #1;
      stall = s; ee = e; flush = f; rst_n = r;
      if (!r) begin
         m_ret5 = 0; m_ret7 = 0; m_stl = 0;
      end
      if (d5) m_ret5++;
      if (c7 != 0 && d7) m_ret7++;
      y.name  = name;
      y.cnt5  = c5;  y.done5 = d5; y.last5 = (c5 == 5) || e;
      y.ret5  = sat(m_ret5, 15);   y.stl5  = sat(m_stl, 15);
      y.cnt7  = c7;  y.done7 = d7; y.last7 = (c7 == 7) || e;
      y.ret7  = sat(m_ret7, 65535); y.stl7 = sat(m_stl, 65535);
      q.push_back(y);
      if (r && s && !f) m_stl++;
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         logic [4:0] e_oh5;
         logic [6:0] e_oh7;
         x = q.pop_front();
         e_oh5 = 5'b00001 << (x.cnt5 - 1);
         chk(x.name, "ClockCount", 32'(cc5), x.cnt5);
         chk(x.name, "StageOneHot", 32'(oh5), 32'(e_oh5));
         chk(x.name, "InstrDone", 32'(done5), 32'(x.done5));
         chk(x.name, "LastStage", 32'(last5), 32'(x.last5));
         chk(x.name, "RetiredCount", 32'(ret5), x.ret5);
         chk(x.name, "StallCount", 32'(stl5), x.stl5);
         if (x.cnt7 != 0) begin
            e_oh7 = 7'b0000001 << (x.cnt7 - 1);
            chk(x.name, "ClockCount7", 32'(cc7), x.cnt7);
            chk(x.name, "StageOneHot7", 32'(oh7), 32'(e_oh7));
            chk(x.name, "InstrDone7", 32'(done7), 32'(x.done7));
            chk(x.name, "LastStage7", 32'(last7), 32'(x.last7));
            chk(x.name, "RetiredCount7", 32'(ret7), x.ret7);
            chk(x.name, "StallCount7", 32'(stl7), x.stl7);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned c5, c7;
      rst_n = 1'b0; stall = 1'b0; ee = 1'b0; flush = 1'b0;
      repeat (2) @(posedge clk);

      step("reset",   0, 0, 0, 0, 1, 0, 1, 0);
      step("release", 0, 0, 0, 1, 1, 0, 1, 0);
      for (int unsigned i = 1; i <= 11; i++) begin
         c5 = (i % 5) + 1; c7 = (i % 7) + 1;
         step("idle", 0, 0, 0, 1, c5, c5 == 1, c7, c7 == 1);
      end

      step("ee_s3",     0, 1, 0, 1, 3, 0, 0, 0);
      step("ee_retire", 0, 0, 0, 1, 1, 1, 0, 0);

      step("stall1",    1, 1, 0, 1, 2, 0, 0, 0);
      step("stall2",    1, 1, 0, 1, 2, 0, 0, 0);
      step("stall3",    1, 1, 0, 1, 2, 0, 0, 0);
      step("stall_end", 0, 0, 0, 1, 2, 0, 0, 0);
      step("advance",   0, 0, 0, 1, 3, 0, 0, 0);

      step("flush_stall", 1, 0, 1, 1, 4, 0, 0, 0);
      step("flushed",     0, 0, 0, 1, 1, 0, 0, 0);
      step("post_flush",  0, 0, 0, 1, 2, 0, 0, 0);

      step("rst_mid",  0, 0, 0, 0, 1, 0, 1, 0);
      step("rst_hold", 0, 0, 0, 0, 1, 0, 1, 0);
      step("rst_rel",  0, 0, 0, 1, 1, 0, 1, 0);
      for (int unsigned i = 1; i <= 109; i++) begin
         c5 = (i % 5) + 1; c7 = (i % 7) + 1;
         step("run", 0, 0, 0, 1, c5, c5 == 1, c7, c7 == 1);
      end

      step("ee_s1",      0, 1, 0, 1, 1, 1, 0, 0);
      step("ee_s1_ret",  0, 0, 0, 1, 1, 1, 0, 0);
      step("s2",         0, 0, 0, 1, 2, 0, 0, 0);
      step("s3",         0, 0, 0, 1, 3, 0, 0, 0);
      step("s4",         0, 0, 0, 1, 4, 0, 0, 0);
      step("ee_s5",      0, 1, 0, 1, 5, 0, 0, 0);
      step("ee_s5_ret",  0, 0, 0, 1, 1, 1, 0, 0);
      step("tail",       0, 0, 0, 1, 2, 0, 0, 0);

      repeat (3) @(negedge clk);
      #1;
      chk("end", "pending", 32'(q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
